uart_rx_param: RTL and testbench

- Parametrised successor to the fixed 8N1 UART receiver.
- Configurable data width, parity and stop bits; oversampled start detection with false-start rejection.
- Per-word parity and framing error flags; small output FIFO with valid/ready pop handshake.
- Sits between the board-level rx pin and the command/byte consumer logic.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_param.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
`timescale 1ns/1ps
package uart_rx_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per oversample tick, truncated, never below one
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received words. Pointers carry one
// extra wrap bit so full/empty are decoded from an MSB compare.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Read/write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversampled bit timing with
// false-start rejection, parity/framing checks and an output FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN replaces the single
// centre sample with a 2-of-3 vote over consecutive ticks.
`timescale 1ns/1ps
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 8,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int DIV     = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int ENTRY_W = DATA_BITS + 2;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_e            r_state;
    rx_state_e            w_state_next;
    logic                 r_sync1;
    logic                 r_rxs;
    logic                 r_rxs_prev;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_centre;
    logic                 w_bit;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_head;

    // Two-flop synchroniser plus previous value for edge detect, idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    assign w_fall   = r_rxs_prev && !r_rxs;
    assign w_tick   = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);
    assign w_centre = w_tick &&
                      (r_tick_cnt == ((r_state == ST_START) ? HALF_LAST : FULL_LAST));

    // Tick divider, held at zero in IDLE so bit phase follows the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_div_cnt <= '0;
        else if (r_state == ST_IDLE)   r_div_cnt <= '0;
        else if (w_tick)               r_div_cnt <= '0;
        else                           r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    // Ticks within the current bit; wraps at each bit centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_tick_cnt <= '0;
        else if (r_state == ST_IDLE)   r_tick_cnt <= '0;
        else if (w_centre)             r_tick_cnt <= '0;
        else if (w_tick)               r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_hist;

    // Line history at the two preceding ticks; the vote closes on the
    // centre tick so every decision lands on the same clock as the
    // single-sample build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_hist <= 2'b11;
        else if (w_tick) r_hist <= {r_hist[0], r_rxs};
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxs) | (r_hist[0] & r_rxs);
`else
    assign w_bit = r_rxs;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and push strobe
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_fall) w_state_next = ST_START;
            ST_START:  if (w_centre) w_state_next = w_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_centre && (r_bit_cnt == DATA_LAST))
                           w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_centre) w_state_next = ST_STOP;
            ST_STOP:   if (w_centre && (r_bit_cnt == STOP_LAST)) begin
                           w_state_next = ST_IDLE;
                           w_push       = 1'b1;
                       end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Data shifter, bit counter and per-word error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_fall) begin
                    r_bit_cnt <= '0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
                ST_DATA: if (w_centre) begin
                    r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
                end
                ST_PARITY: if (w_centre) begin
                    r_perr <= (PARITY == PAR_EVEN) ? (^r_shift ^ w_bit) : ~(^r_shift ^ w_bit);
                end
                ST_STOP: if (w_centre) begin
                    if (!w_bit) r_ferr <= 1'b1;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The final stop sample folds straight into the pushed frame flag
    assign w_entry = {r_shift, r_perr, r_ferr | !w_bit};
    assign w_pop   = data_ready && !w_empty;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_head  (w_head)
    );

    // Sticky overrun, cleared by the next successful pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
        else if (w_pop)  r_overrun <= 1'b0;
    end

    assign data_valid = !w_empty;
    assign data_out   = w_empty ? '0 : w_head[ENTRY_W-1:2];
    assign parity_err = !w_empty && w_head[1];
    assign frame_err  = !w_empty && w_head[0];
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: an 8N1 instance and an
// even-parity, two-stop instance, each with its own expected-word queue.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = 104;   // 13 clocks/tick * 8 ticks/bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    [2];
    logic       ready [2];
    logic [7:0] dout  [2];
    logic       valid [2];
    logic       perr  [2];
    logic       ferr  [2];
    logic       ovr   [2];

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] qa [$];
    logic [9:0] qb [$];
    bit         rnd_en = 1'b0;
    bit         ready_force = 1'b0;
    bit         exp_ovr = 1'b0;

    uart_rx_param #(.PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data_out(dout[0]), .data_valid(valid[0]),
        .data_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

    uart_rx_param #(.PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data_out(dout[1]), .data_valid(valid[1]),
        .data_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

    always #500 clk = ~clk;

    // Consumer ready, either random per cycle or a fixed level
    always @(posedge clk) begin
        #1;
        ready[0] = rnd_en ? 1'($urandom_range(0, 1)) : ready_force;
        ready[1] = rnd_en ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input int w, input string name);
        logic [11:0] v;
        v = {dout[w], valid[w], perr[w], ferr[w], ovr[w]};
        check(name, 32'(v), 0);
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? qa.size() : qb.size();
    endfunction

    // Compare one handshaken word against the head of the expected queue
    task automatic mon_word(input int w);
        logic [9:0] e;
        logic [9:0] got;
        got = {dout[w], perr[w], ferr[w]};
        n_checks++;
        if (qsize(w) == 0) begin
            n_errors++;
            $display("FAIL unexpected_word dut%0d: got data=%h perr=%b ferr=%b, expected none",
                     w, got[9:2], got[1], got[0]);
        end else begin
            e = (w == 0) ? qa.pop_front() : qb.pop_front();
            if (got !== e) begin
                n_errors++;
                $display("FAIL word dut%0d: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                         w, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
            end else begin
                $display("dut%0d word data=%h perr=%b ferr=%b ok", w, got[9:2], got[1], got[0]);
            end
        end
    endtask

    // Monitor: pops and compares whenever a word is handed over
    always @(negedge clk) begin
        if (valid[0] && ready[0]) mon_word(0);
        if (valid[1] && ready[1]) mon_word(1);
    end

    // Drive one frame and queue the word the receiver should deliver
    task automatic send(input int w, input logic [7:0] d, input bit pflip, input bit sbad);
        logic       bits [$];
        bit         pb;
        int         nstop;
        int         bad_idx;
        logic       p_e;
        logic       f_e;
        logic [9:0] ent;
        p_e = 1'b0;
        f_e = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (w == 1) begin
            pb = 1'($countones(d) % 2) ^ pflip;
            bits.push_back(pb);
            // even parity: data plus parity bit must hold an even count of ones
            p_e = (($countones(d) + int'(pb)) % 2) != 0;
            nstop = 2;
        end else begin
            nstop = 1;
        end
        bad_idx = sbad ? int'($urandom_range(0, nstop - 1)) : -1;
        for (int s = 0; s < nstop; s++) begin
            bits.push_back(s != bad_idx);
            if (s == bad_idx) f_e = 1'b1;
        end
        ent = {d, p_e, f_e};
        if (!rnd_en && !ready_force && qsize(w) >= DEPTH) begin
            exp_ovr = 1'b1;
            $display("dut%0d frame %h sent into full fifo, expect drop", w, d);
        end else if (w == 0) begin
            qa.push_back(ent);
        end else begin
            qb.push_back(ent);
        end
        foreach (bits[i]) begin
            rx[w] = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        rx[w] = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    // Wait, with a bound, until all expected words were consumed
    task automatic wait_drain(input int w);
        int cnt;
        cnt = 0;
        while ((qsize(w) != 0 || valid[w]) && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_timeout", (cnt >= 5000) ? 1 : 0, 0);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin
        #90_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        summary();
        $finish;
    end

    initial begin
        int seen;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic 8N1, framing error then clean recovery
        ready_force = 1'b1;
        send(0, 8'h31, 1'b0, 1'b0);
        wait_drain(0);
        send(0, 8'hA5, 1'b0, 1'b1);
        send(0, 8'h5A, 1'b0, 1'b0);
        wait_drain(0);

        // 20 us glitch must be rejected as a false start
        @(posedge clk);
        rx[0] = 1'b0;
        repeat (20) @(posedge clk);
        rx[0] = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid[0]) seen++;
        end
        check("glitch_no_push", seen, 0);
        send(0, 8'hC3, 1'b0, 1'b0);
        wait_drain(0);

        // Random words with random consumer back-pressure
        rnd_en = 1'b1;
        repeat (12) send(0, 8'($urandom), 1'b0, $urandom_range(0, 3) == 0);
        wait_drain(0);

        // Overrun: five frames into a four-entry FIFO with no consumer
        rnd_en = 1'b0;
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        for (int v = 1; v <= 5; v++) send(0, 8'(v), 1'b0, 1'b0);
        @(negedge clk);
        check("overrun_set", 32'(ovr[0]), 32'(exp_ovr));
        check("full_valid", 32'(valid[0]), 1);
        ready_force = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
        @(negedge clk);
        exp_ovr = 1'b0;
        check("overrun_clear", 32'(ovr[0]), 32'(exp_ovr));
        check("remaining_held", 32'(valid[0]), 1);
        ready_force = 1'b1;
        wait_drain(0);
        check_idle(0, "empty_after_drain");

        // Even parity, two stop bits
        send(1, 8'h31, 1'b1, 1'b0);
        send(1, 8'h31, 1'b0, 1'b0);
        wait_drain(1);
        rnd_en = 1'b1;
        repeat (12) send(1, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        wait_drain(1);
        rnd_en = 1'b0;
        ready_force = 1'b1;

        // Reset during data bit 3, then a clean word
        rx[0] = 1'b0;
        repeat (BIT_CLKS * 4 + BIT_CLKS / 2) @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "midframe_reset_a");
        check_idle(1, "midframe_reset_b");
        rx[0] = 1'b1;
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        check("no_partial_word", 32'(valid[0]), 0);
        send(0, 8'h7E, 1'b0, 1'b0);
        wait_drain(0);

        summary();
        $finish;
    end

endmodule
